// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one single-ported, fixed-latency read memory between fetch and load.
// Latency: grant -> response valid in LATENCY+1 cycles; one read issued per LATENCY+1 cycles.
// Backpressure: requesters hold req/addr until gnt; loads win, fetch forced after MAX_LOAD_STREAK loads.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   f_req/f_addr -> f_gnt     fetch request, accepted combinationally when f_gnt = 1
//   f_valid/f_data            fetch response pulse; f_data held until the next fetch response
//   l_req/l_addr -> l_gnt     load request, accepted combinationally when l_gnt = 1
//   l_valid/l_data            load response pulse; l_data held until the next load response
//   mem_en/mem_addr/mem_data  memory read strobe, address (0 when idle), data LATENCY cycles later
//   busy                      a read is outstanding
module mem_read_arbiter #(
  parameter int AW              = 61,
  parameter int DW              = 64,
  parameter int LATENCY         = 2,
  parameter int MAX_LOAD_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [0:AW-1] f_addr,
  output logic          f_gnt,
  output logic          f_valid,
  output logic [0:DW-1] f_data,
  input  logic          l_req,
  input  logic [0:AW-1] l_addr,
  output logic          l_gnt,
  output logic          l_valid,
  output logic [0:DW-1] l_data,
  output logic          mem_en,
  output logic [0:AW-1] mem_addr,
  input  logic [0:DW-1] mem_data,
  output logic          busy
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int SW = $clog2(MAX_LOAD_STREAK + 1);
  localparam logic [CW-1:0] CNT_INIT   = CW'(LATENCY - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LOAD_STREAK);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic          own, ownNext;      // 0 = fetch owns the outstanding read, 1 = load
  logic [SW-1:0] streak, streakNext;
  logic          eligible;
  logic          fetchForced;
  logic          capture;

  // Grant, memory strobe and response outputs.
  always_comb begin
    eligible    = !rst && (state != BUSY);
    fetchForced = f_req && (streak == STREAK_MAX);
    l_gnt       = eligible && l_req && !fetchForced;
    f_gnt       = eligible && f_req && !l_gnt;
    mem_en      = f_gnt | l_gnt;
    mem_addr    = l_gnt ? l_addr : (f_gnt ? f_addr : '0);
    busy        = (state == BUSY);
    // A RESP cycle that coincides with reset belongs to a discarded read.
    f_valid     = !rst && (state == RESP) && !own;
    l_valid     = !rst && (state == RESP) && own;
    capture     = (state == BUSY) && (cnt == '0);
  end

  // Next-state logic.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    ownNext    = own;
    streakNext = streak;

    // A load grant with fetch waiting implies streak < MAX (otherwise fetch
    // would have been forced), so the increment cannot overflow.
    if (l_gnt) begin
      streakNext = f_req ? streak + SW'(1) : '0;
    end else if (f_gnt) begin
      streakNext = '0;
    end

    case (state)
      IDLE, RESP: begin
        if (mem_en) begin
          stateNext = BUSY;
          cntNext   = CNT_INIT;
          ownNext   = l_gnt;
        end else begin
          stateNext = IDLE;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cntNext = cnt - CW'(1);
        end else begin
          stateNext = RESP;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      own    <= 1'b0;
      streak <= '0;
      f_data <= '0;
      l_data <= '0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      own    <= ownNext;
      streak <= streakNext;
      // Only the owner's data register is written; the other keeps its value.
      if (capture) begin
        if (own) l_data <= mem_data;
        else     f_data <= mem_data;
      end
    end
  end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares one single-ported, fixed-latency read memory between the instruction-fetch requester and the load (ld/ldu) requester of the PowerPC core.
- Replaces the dual combinational read ports with a request/grant/response handshake, which lets the core move to a multi-cycle memory.
- Load requests have priority. A streak counter guarantees that fetch cannot starve.
- Sits between the core's fetch/load logic and the memory model.

Parameters:
AW, 61, doubleword address width (bit numbering [0:AW-1], MSB = bit 0)
DW, 64, data width ([0:DW-1])
LATENCY, 2, cycles from mem_en sampled to mem_data valid; legal range >= 1
MAX_LOAD_STREAK, 4, maximum consecutive load grants while a fetch is pending; legal range >= 1

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous reset, active-high
f_req  in  1  fetch request; held with f_addr stable until f_gnt
f_addr  in  AW  fetch doubleword address
f_gnt  out  1  fetch request accepted this cycle (combinational)
f_valid  out  1  one-cycle pulse: f_data holds the fetch response
f_data  out  DW  fetch response data; held until the next fetch response
l_req  in  1  load request; held with l_addr stable until l_gnt
l_addr  in  AW  load doubleword address
l_gnt  out  1  load request accepted this cycle (combinational)
l_valid  out  1  one-cycle pulse: l_data holds the load response
l_data  out  DW  load response data; held until the next load response
mem_en  out  1  memory read strobe, equal to f_gnt | l_gnt
mem_addr  out  AW  address of the granted request; 0 when mem_en = 0
mem_data  in  DW  memory read data, valid LATENCY cycles after mem_en
busy  out  1  a read is outstanding (state BUSY)

Behaviour:
- States:
  - IDLE: no read outstanding.
  - BUSY: waiting on memory; holds a latency counter cnt and owner bit own (0 = fetch, 1 = load).
  - RESP: one cycle; the valid output of the owner is high.
- Grants are evaluated only in IDLE or RESP. In BUSY, f_gnt = l_gnt = 0.
- Arbitration in an eligible cycle:
  - Only one requester active: it is granted.
  - Both active: load wins, unless streak == MAX_LOAD_STREAK, in which case fetch wins.
  - At most one gnt per cycle.
- streak counter, saturating at MAX_LOAD_STREAK:
  - Load grant with f_req = 1: streak + 1.
  - Load grant with f_req = 0: streak = 0.
  - Fetch grant: streak = 0.
  - No grant: unchanged.
- On a grant in cycle N:
  - mem_en = 1 and mem_addr = the granted address in cycle N.
  - Next state is BUSY with cnt = LATENCY - 1 and own = the granted requester.
- In BUSY:
  - cnt != 0: decrement.
  - cnt == 0: capture mem_data into f_data or l_data according to own; go to RESP.
  - The capture is at the edge ending cycle N+LATENCY.
- In RESP (cycle N+LATENCY+1), the owner's valid is high for exactly one cycle.
  - A grant in the same cycle returns to BUSY (back-to-back operation).
  - With no grant, the next state is IDLE.
- Throughput: one read per LATENCY+1 cycles. Response latency from grant: LATENCY+1 cycles.
- The non-owner's data register and valid output are untouched by a response.
- Requesters may drop req only after gnt. Behaviour for a req withdrawn before gnt is defined as simply not granting it.
- Reset (synchronous, any state, including mid-BUSY):
  - State goes to IDLE; cnt, own and streak are cleared.
  - f_valid, l_valid, busy, f_data and l_data are 0.
  - The in-flight read is discarded; no valid is ever produced for it.
  - While rst = 1, f_gnt = l_gnt = mem_en = 0 and mem_addr = 0.
- mem_data is ignored in every cycle other than the capture cycle.

Test Plan (LATENCY = 2, MAX_LOAD_STREAK = 4):
- Single fetch: f_req = 1, f_addr = 0x10 in cycle 0; mem returns 0x7C0802A6_38210010 in cycle 2.
  - Expect f_gnt, mem_en and mem_addr = 0x10 in cycle 0; busy in cycles 1–2.
  - Expect f_valid in cycle 3 only, with f_data = 0x7C0802A638210010; l_valid stays 0.
- Simultaneous requests: f_req = 1 (0x20) and l_req = 1 (0x400) both in cycle 0.
  - Expect l_gnt in cycle 0 and l_valid in cycle 3.
  - Expect f_gnt in cycle 3 (RESP cycle) and f_valid in cycle 6.
- Starvation bound: l_req and f_req both held high continuously.
  - Expect load grants at cycles 0, 3, 6 and 9, then a fetch grant at cycle 12.
  - The streak then resets, and the next grant (cycle 15) is a load.
- Back-to-back loads with f_req = 0: l_req held high with addresses 0x1, 0x2, 0x3.
  - Expect grants at cycles 0, 3 and 6, and l_valid at cycles 3, 6 and 9 with the matching data.
  - streak stays 0 throughout.
- Reset mid-operation: fetch granted in cycle 0; rst = 1 in cycle 1.
  - Expect busy = 0 and f_valid never asserted for that read; f_data = 0.
  - A new f_req in cycle 2 is granted in cycle 2.
- Data isolation: load response 0xDEADBEEF_00000001 followed by a fetch response 0x1.
  - l_data must still read 0xDEADBEEF00000001 after f_valid.
